// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall unit; tracks in-flight destination tags over DEPTH post-EX stages.
// Forwarding and stall are combinational from the tag pipeline; hold_i freezes tags and the stall counter.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic                      ex_valid_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_memread_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]        id_use_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic                      load_use_stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic                      fwd_err_o
);

    // Index 0 is stage 1 (MEM), index DEPTH-1 is the last write-back stage.
    logic [DEPTH-1:0]             v_q, rw_q, ld_q;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q;
    logic [DEPTH-1:0]             live;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         err_now;
    logic                         found;
    logic [REG_AW-1:0]            src;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            live[k] = v_q[k] & rw_q[k] & (rd_q[k] != '0);
        end
    end

    // The youngest live match wins; an unready load blocks the search of older stages.
    always_comb begin
        fwd_sel_o = '0;
        err_now   = 1'b0;
        found     = 1'b0;
        src       = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            found = 1'b0;
            src   = ex_src_i[j*REG_AW +: REG_AW];
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && live[k] && (src != '0) && (rd_q[k] == src)) begin
                    found = 1'b1;
                    if (ld_q[k] && (k < LOAD_LAT)) begin
                        err_now = 1'b1;
                    end else begin
                        fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        load_use_stall_o = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (id_use_i[j] && (id_src_i[j*REG_AW +: REG_AW] != '0)) begin
                if (ex_valid_i && ex_regwrite_i && ex_memread_i &&
                    (ex_rd_i == id_src_i[j*REG_AW +: REG_AW])) begin
                    load_use_stall_o = 1'b1;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if ((k < LOAD_LAT - 1) && live[k] && ld_q[k] &&
                        (rd_q[k] == id_src_i[j*REG_AW +: REG_AW])) begin
                        load_use_stall_o = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i && load_use_stall_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | err_now;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            v_q   <= '0;
            rw_q  <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (!hold_i) begin
                v_q[0]  <= ex_valid_i;
                rw_q[0] <= ex_regwrite_i;
                ld_q[0] <= ex_memread_i;
                rd_q[0] <= ex_rd_i;
                for (int k = 1; k < DEPTH; k++) begin
                    v_q[k]  <= v_q[k-1];
                    rw_q[k] <= rw_q[k-1];
                    ld_q[k] <= ld_q[k-1];
                    rd_q[k] <= rd_q[k-1];
                end
            end
        end
    end

    assign stall_cnt_o = cnt_q;
    assign fwd_err_o   = err_q;

endmodule
